alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the core's combinational ALU. Width is generic, and the flags register (C, Z, N) lives inside the block.
- Adds a valid/ready handshake on both sides, plus multi-cycle iterative shifts that move one bit per cycle.
- Sits in the execute stage between the register-file read ports and the write-back stage.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), shift-amount width; taken from operand2[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- operation  in  4  opcode (see Behaviour).
- operand1  in  WIDTH  first operand.
- operand2  in  WIDTH  second operand / shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags_out  out  3  registered flags: [0]=C, [1]=Z, [2]=N.
- flags_load  in  1  overwrite flags register with flags_in (e.g. RTI/restore).
- flags_in  in  3  value for flags_load.
- busy  out  1  high in SHIFT state.

Behaviour:
- Clock and reset: one clock (clk). reset_b is asynchronous and active-low.
- Reset values: state=IDLE, result=0, flags_out=3'b000, out_valid=0, busy=0.
- in_ready is combinational: high when state==IDLE, or when state==DONE and out_ready==1.
- A request is accepted when in_valid & in_ready. Operands and opcode are captured at that edge.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on accept:
    - Non-shift op → DONE.
    - Shift op with amt>0 → SHIFT.
    - Shift op with amt==0 → DONE.
  - SHIFT: shifts one bit per cycle and decrements a counter. When the counter reaches 0 → DONE.
  - DONE: out_valid=1. result and flags_out are stable until out_ready.
    - out_ready & in_valid → treat as an IDLE accept (back-to-back).
    - out_ready & !in_valid → IDLE.
- Latency: non-shift ops and amt==0 shifts assert out_valid 1 cycle after accept. Shifts with amt>0 assert out_valid 1+amt cycles after accept. Sustained throughput is one non-shift op per cycle.
- Opcodes (mod 2^WIDTH arithmetic):
  - 0000 ADD: {C,result}=op1+op2.
  - 0001 SETC: C=1; result=op1.
  - 0010 SUB: result=op1-op2; C=1 iff op1<op2 unsigned (borrow).
  - 0011 AND: result=op1&op2.
  - 0100 NOT: result=~op1.
  - 0101 PASS1: result=op1.
  - 0110 PASS2: result=op2.
  - 0111 CLRC: C=0; result=op1.
  - 1000 SHL: logical left by amt; C=last bit shifted out.
  - 1001 SHR: logical right by amt; C=last bit shifted out.
  - 1010 ADC: {C,result}=op1+op2+C (C as held at accept).
  - 1011-1111 illegal: result=0, flags unchanged, still completes in 1 cycle. Never drives X/Z.
- Flag update rules:
  - Z and N (N=result[WIDTH-1]) update for ADD, SUB, AND, NOT, SHL, SHR, ADC.
  - PASS1, PASS2, SETC and CLRC leave Z and N unchanged.
  - C is updated only where stated above.
  - A shift with amt==0 leaves C unchanged and updates Z and N.
- Flags commit on the edge that enters DONE, together with result.
- flags_load: when high, the flags register takes flags_in on that edge in any state. This overrides an operation's flag commit on the same edge. result is unaffected.
- Flags are held in DONE while out_valid waits for out_ready (no double commit).
- Reset asserted mid-shift or in DONE: the block returns to reset values immediately (asynchronous). The pending operation is discarded and no output is produced for it.
- in_valid while busy is ignored (in_ready=0). Input-side handshake is not required to be stable before acceptance.

Test Plan (WIDTH=16):
- ADD 0xFFFF + 0x0001, out_ready=1 → out_valid 1 cycle after accept; result=0x0000, flags_out=3'b011 (C=1, Z=1, N=0).
- SUB 0x0003 - 0x0005, then ADC 0x0001 + 0x0001 back-to-back → SUB: result=0xFFFE, C=1, N=1, Z=0. ADC: result=0x0003, C=0; both outputs on consecutive cycles.
- SHL op1=0x8001, amt=4 → busy high 4 cycles, in_ready=0 throughout; out_valid at accept+5; result=0x0010, C=0. Repeat with amt=1 → result=0x0002, C=1.
- DONE with out_ready=0 for 3 cycles → result/flags_out/out_valid held constant; in_ready=0. Raising out_ready together with in_valid accepts the next op on the same edge.
- flags_load=1 with flags_in=3'b101 on the same edge as an ADD completing with flags 3'b010 → flags_out=3'b101, result=ADD sum.
- Reset pulse during SHR amt=10 at cycle 5 → outputs return to 0 and state goes to IDLE; no out_valid after release. Illegal opcode 1100 → result=0, flags unchanged, out_valid after 1 cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file read side, alu_seq and write-back.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high; ready may depend combinationally on the peer's ready.
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags_out;
  logic             flags_load;
  logic [2:0]       flags_in;
  logic             busy;

  modport master (
    output in_valid, operation, operand1, operand2, out_ready, flags_load, flags_in,
    input  in_ready, out_valid, result, flags_out, busy
  );

  modport slave (
    input  in_valid, operation, operand1, operand2, out_ready, flags_load, flags_in,
    output in_ready, out_valid, result, flags_out, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with internal C/Z/N flags, valid/ready on both sides and bit-serial shifts.
// Flags are packed {N, Z, C}.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset_b,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SETC = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_PAS1 = 4'b0101;
  localparam logic [3:0] OP_PAS2 = 4'b0110;
  localparam logic [3:0] OP_CLRC = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ADC  = 4'b1010;

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       flags_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   cnt;
  logic             dir_right;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_zn;
  logic [2:0]       alu_flags;
  logic [WIDTH-1:0] shifted;
  logic             shift_c;

  assign bus.in_ready  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state;

  assign amt      = bus.operand2[SHW-1:0];
  assign is_shift = (bus.operation == OP_SHL) || (bus.operation == OP_SHR);

  // ADC adds the carry as it stands in the register at accept time.
  assign add_full = {1'b0, bus.operand1} + {1'b0, bus.operand2}
                  + {{WIDTH{1'b0}}, (bus.operation == OP_ADC) & flags_q[0]};

  always_comb begin
    alu_res = '0;
    alu_c   = flags_q[0];
    alu_zn  = 1'b0;
    case (bus.operation)
      OP_ADD, OP_ADC: begin alu_res = add_full[WIDTH-1:0]; alu_c = add_full[WIDTH]; alu_zn = 1'b1; end
      OP_SETC:        begin alu_res = bus.operand1; alu_c = 1'b1; end
      OP_SUB:         begin alu_res = bus.operand1 - bus.operand2;
                            alu_c = (bus.operand1 < bus.operand2); alu_zn = 1'b1; end
      OP_AND:         begin alu_res = bus.operand1 & bus.operand2; alu_zn = 1'b1; end
      OP_NOT:         begin alu_res = ~bus.operand1; alu_zn = 1'b1; end
      OP_PAS1:        alu_res = bus.operand1;
      OP_PAS2:        alu_res = bus.operand2;
      OP_CLRC:        begin alu_res = bus.operand1; alu_c = 1'b0; end
      OP_SHL, OP_SHR: begin alu_res = bus.operand1; alu_zn = 1'b1; end  // zero-amount shift only
      default:        alu_res = '0;
    endcase
    alu_flags    = flags_q;
    alu_flags[0] = alu_c;
    if (alu_zn) begin
      alu_flags[1] = (alu_res == '0);
      alu_flags[2] = alu_res[WIDTH-1];
    end
  end

  always_comb begin
    shifted = dir_right ? (shreg >> 1) : (shreg << 1);
    shift_c = dir_right ? shreg[0] : shreg[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= S_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      dir_right   <= 1'b0;
    end else begin
      if (accept) begin
        if (is_shift && (amt != '0)) begin
          shreg       <= bus.operand1;
          cnt         <= amt;
          dir_right   <= bus.operation[0];
          state       <= S_SHIFT;
          busy_q      <= 1'b1;
          out_valid_q <= 1'b0;
        end else begin
          result_q    <= alu_res;
          flags_q     <= alu_flags;
          state       <= S_DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end else begin
        case (state)
          S_SHIFT: begin
            shreg <= shifted;
            cnt   <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              result_q    <= shifted;
              flags_q     <= {shifted[WIDTH-1], (shifted == '0), shift_c};
              state       <= S_DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
          S_DONE: begin
            if (bus.out_ready) begin
              state       <= S_IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      // An explicit flags load wins over any commit on the same edge.
      if (bus.flags_load) flags_q <= bus.flags_in;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed cases plus random traffic checked against a reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic       clk;
  logic       reset_b;
  logic [1:0] dbg_state;
  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] exp_q[$];   // {N,Z,C,result}
  int          lat_q[$];   // cycle number of first out_valid
  logic [2:0]  m_flags;
  logic        rand_rdy;
  logic        new_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole-word arithmetic straight from the opcode table.
  function automatic logic [18:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [2:0] f);
    logic [15:0] r;
    logic        c;
    logic        zn;
    logic [16:0] s;
    logic [31:0] wide;
    int          amt;
    amt = int'(b[3:0]);
    r = 16'h0; c = f[0]; zn = 1'b0;
    case (op)
      4'd0:  begin s = 17'(a) + 17'(b); r = s[15:0]; c = s[16]; zn = 1'b1; end
      4'd1:  begin r = a; c = 1'b1; end
      4'd2:  begin r = a - b; c = (a < b); zn = 1'b1; end
      4'd3:  begin r = a & b; zn = 1'b1; end
      4'd4:  begin r = ~a; zn = 1'b1; end
      4'd5:  r = a;
      4'd6:  r = b;
      4'd7:  begin r = a; c = 1'b0; end
      4'd8:  begin
               zn = 1'b1; wide = 32'(a) << amt; r = wide[15:0];
               if (amt != 0) c = wide[16];
             end
      4'd9:  begin
               zn = 1'b1; r = a >> amt;
               if (amt != 0) begin wide = 32'(a) >> (amt - 1); c = wide[0]; end
             end
      4'd10: begin s = 17'(a) + 17'(b) + 17'(f[0]); r = s[15:0]; c = s[16]; zn = 1'b1; end
      default: r = 16'h0;
    endcase
    return {(zn ? r[15] : f[2]), (zn ? (r == 16'h0) : f[1]), c, r};
  endfunction

  // driver: starts at posedge+2, returns at posedge+2 after the accepting edge
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic fl = 1'b0, input logic [2:0] fin = 3'b000);
    logic [18:0] e;
    int          n;
    int          lat;
    bus.in_valid   = 1'b1;
    bus.operation  = op;
    bus.operand1   = a;
    bus.operand2   = b;
    bus.flags_load = fl;
    bus.flags_in   = fin;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    e = ref_op(op, a, b, m_flags);
    if (fl) e[18:16] = fin;
    m_flags = e[18:16];
    lat = ((op == 4'd8 || op == 4'd9) && b[3:0] != 4'd0) ? 1 + int'(b[3:0]) : 1;
    exp_q.push_back(e);
    lat_q.push_back(cyc + lat);
    @(posedge clk); #2;
    bus.in_valid   = 1'b0;
    bus.flags_load = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] res, input logic [2:0] flg);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
      if (n > 40) begin
        check({tag, "_timeout"}, 32'd0, 32'd1);
        return;
      end
    end
    check({tag, "_res"}, 32'(bus.result), 32'(res));
    check({tag, "_flags"}, 32'(bus.flags_out), 32'(flg));
  endtask

  // scoreboard: latency on first appearance, payload every valid cycle (covers hold)
  always @(negedge clk) begin
    if (!reset_b) new_out = 1'b1;
    else if (bus.out_valid) begin
      if (new_out) begin
        if (lat_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
        else check("latency", 32'(cyc), 32'(lat_q.pop_front()));
        new_out = 1'b0;
      end
      if (exp_q.size() != 0) begin
        check("sb_result", 32'(bus.result), 32'(exp_q[0][15:0]));
        check("sb_flags", 32'(bus.flags_out), 32'(exp_q[0][18:16]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
      if (bus.out_ready) new_out = 1'b1;
    end else new_out = 1'b1;
  end

  always begin
    @(posedge clk); #2;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 9) < 7);
  end

  initial begin
    int nb;
    int bad;
    int n;
    reset_b = 1'b0;
    rand_rdy = 1'b0;
    m_flags = 3'b000;
    new_out = 1'b1;
    bus.in_valid = 1'b0; bus.operation = 4'h0; bus.operand1 = '0; bus.operand2 = '0;
    bus.out_ready = 1'b1; bus.flags_load = 1'b0; bus.flags_in = 3'b000;

    @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags_out), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #2;
    reset_b = 1'b1;
    @(posedge clk); #2;

    // carry-out wraps to zero
    send(4'd0, 16'hFFFF, 16'h0001);
    expect_out("add_wrap", 16'h0000, 3'b011);
    @(posedge clk); #2;

    // back-to-back SUB then ADC using the borrow
    send(4'd2, 16'h0003, 16'h0005);
    send(4'd10, 16'h0001, 16'h0001);
    expect_out("adc_b2b", 16'h0003, 3'b000);
    @(posedge clk); #2;

    // multi-cycle shift: busy span and in_ready blocked
    send(4'd8, 16'h8001, 16'h0004);
    nb = 0; bad = 0; n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.busy) begin nb++; if (bus.in_ready) bad++; end
      n++;
      if (n > 40) begin check("shl4_timeout", 32'd0, 32'd1); break; end
    end
    check("shl4_busy_cycles", 32'(nb), 32'd4);
    check("shl4_in_ready_busy", 32'(bad), 32'd0);
    check("shl4_res", 32'(bus.result), 32'h0010);
    check("shl4_c", 32'(bus.flags_out[0]), 32'd0);
    @(posedge clk); #2;
    send(4'd8, 16'h8001, 16'h0001);
    expect_out("shl1", 16'h0002, 3'b001);
    @(posedge clk); #2;

    // result held while the consumer stalls, then accept on the releasing edge
    bus.out_ready = 1'b0;
    send(4'd0, 16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_res", 32'(bus.result), 32'h3333);
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    send(4'd6, 16'h0000, 16'h00AB);
    expect_out("pass2_after_hold", 16'h00AB, 3'b000);
    @(posedge clk); #2;

    // flags_load overrides the ADD flag commit on the same edge
    send(4'd0, 16'h0000, 16'h0000, 1'b1, 3'b101);
    expect_out("flags_load", 16'h0000, 3'b101);
    @(posedge clk); #2;

    // random traffic with consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom_range(0, 65535));
      b  = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) a = (i % 8 == 0) ? 16'hFFFF : 16'h0000;
      send(op, a, b);
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #2;

    // asynchronous reset in the middle of a long shift discards it
    send(4'd9, 16'hFFFF, 16'd10);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset_b = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result", 32'(bus.result), 32'd0);
    check("mid_rst_flags", 32'(bus.flags_out), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    lat_q.delete();
    m_flags = 3'b000;
    @(posedge clk); #2;
    reset_b = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    check("post_rst_no_valid", 32'(n), 32'd0);
    @(posedge clk); #2;

    // illegal opcode keeps flags and completes in one cycle
    send(4'd1, 16'h0000, 16'h0000);
    expect_out("setc", 16'h0000, 3'b001);
    @(posedge clk); #2;
    send(4'b1100, 16'h1234, 16'h5678);
    expect_out("illegal", 16'h0000, 3'b001);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
